hazard_ctl: RTL
===============

Name: hazard_ctl

Overview:
- Pipeline interlock controller for the five-stage MIPS CPU. The pipeline has no forwarding.
- Keeps a shadow scoreboard of in-flight destination registers for the EX, MEM and WB slots.
- Compares the scoreboard against the source registers of the instruction in ID and drives stall, bubble and flush controls to the PC, IF/ID, ID/EX and EX/MEM registers.
- Also handles taken-branch squash (branch resolved in MEM) and a global freeze for memory wait.

Parameters:
- WB_WRITE_FIRST, 1: 1 = register file writes before reads in the same cycle, so the WB slot is not checked; 0 = the WB slot is also checked.
- CNT_W, 16: width of the statistics counters.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- id_rs  in  5  rs field of the instruction in ID.
- id_rt  in  5  rt field of the instruction in ID.
- id_rd  in  5  rd field of the instruction in ID.
- id_uses_rs  in  1  ID instruction reads rs.
- id_uses_rt  in  1  ID instruction reads rt.
- id_regdst  in  1  1 = destination is rd, 0 = destination is rt (from control decode).
- id_regwrite  in  1  ID instruction writes a register.
- branch_taken  in  1  branch in MEM resolved taken this cycle.
- freeze  in  1  external memory-wait request; holds the whole pipeline.
- pc_we  out  1  PC write enable.
- ifid_we  out  1  IF/ID register write enable.
- ifid_flush  out  1  load a NOP into IF/ID.
- idex_bubble  out  1  zero the control fields entering ID/EX.
- exmem_flush  out  1  zero the control fields entering EX/MEM.
- hz_state  out  2  00 RUN, 01 STALL, 10 FLUSH, 11 FROZEN; registered, diagnostic only.
- stall_cnt  out  CNT_W  stall cycles (optional, see below).
- flush_cnt  out  CNT_W  flush events (optional, see below).

Behaviour:
- Clock and reset: single clock clk. Reset is synchronous and active-high on port reset.
- Scoreboard slots: sb_ex, sb_mem, sb_wb, each holding {valid, reg[4:0]}. Reset clears all valid bits.
- ID destination: id_dst = id_regdst ? id_rd : id_rt. The entry is valid only if id_regwrite=1 and id_dst != 0.
- Hazard: hz = 1 when a valid slot's reg equals id_rs (with id_uses_rs=1) or id_rt (with id_uses_rt=1).
  - Slots checked: sb_ex and sb_mem always; sb_wb only when WB_WRITE_FIRST=0.
  - Register 0 never matches.
- Control outputs are combinational from current inputs and scoreboard state (zero-latency interlock). Priority, highest first:
  - reset: pc_we=0, ifid_we=0, ifid_flush=1, idex_bubble=1, exmem_flush=1.
  - freeze: pc_we=0, ifid_we=0, all flushes/bubbles 0. Scoreboard holds. branch_taken is ignored; the upstream logic holds it asserted until freeze drops.
  - branch_taken: pc_we=1, ifid_we=1, ifid_flush=1, idex_bubble=1, exmem_flush=1.
    - Next state: sb_wb<=sb_mem, sb_mem<=0, sb_ex<=0.
    - A hazard present in the same cycle is discarded.
  - hz: pc_we=0, ifid_we=0, idex_bubble=1.
    - Next state: sb_wb<=sb_mem, sb_mem<=sb_ex, sb_ex<=0.
  - otherwise: pc_we=1, ifid_we=1, everything else 0.
    - Next state: sb_wb<=sb_mem, sb_mem<=sb_ex, sb_ex<={id valid, id_dst}.
- hz_state is registered and reflects the priority branch taken in the previous cycle. Reset value is RUN.
- Stall length: a dependent instruction directly after its producer stalls 2 cycles (WB_WRITE_FIRST=1) or 3 cycles (WB_WRITE_FIRST=0). One independent instruction between producer and consumer shortens the stall by one cycle.
- Reset mid-stall: the scoreboard clears and there is no residual stall after reset deasserts.

Optional Feature:
- Macro: HAZARD_STATS_EN.
- Defined:
  - stall_cnt increments on each cycle in the hz branch.
  - flush_cnt increments on each cycle in the branch_taken branch.
  - Both counters saturate at all-ones and clear on reset.
  - Frozen cycles are not counted.
- Undefined: stall_cnt and flush_cnt are tied to 0 and no counter flops are built.

Test Plan:
- Default params, reset: `add $3,$1,$2` then `sub $4,$3,$5` back-to-back -> 2 cycles of pc_we=0 and idex_bubble=1, then normal flow; stall_cnt=2.
- WB_WRITE_FIRST=0, same sequence -> 3 stall cycles; stall_cnt=3.
- Write to $0 followed by a reader of $0, and `lw $7` followed by an instruction with id_uses_rt=0 reading $7 only via rt -> no stall.
- Hazard and branch_taken in the same cycle -> all three flushes asserted, pc_we=1, no stall next cycle; flush_cnt=1, stall_cnt unchanged.
- freeze=1 for 4 cycles in the middle of a 2-cycle stall -> outputs held with pc_we=0 and no bubbles; after release, exactly 1 remaining stall cycle; counters count no frozen cycles.
- reset asserted during STALL -> next cycle hz_state=RUN, scoreboard empty, pc_we=1 once reset drops.

Source files
------------

// File: rtl/hazard_ctl_if.sv
// ID-stage / hazard controller bundle.
// Master drives the ID fields, slave returns interlock controls.
interface hazard_ctl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic [4:0]       id_rd;
  logic             id_uses_rs;
  logic             id_uses_rt;
  logic             id_regdst;
  logic             id_regwrite;
  logic             branch_taken;
  logic             freeze;
  logic             pc_we;
  logic             ifid_we;
  logic             ifid_flush;
  logic             idex_bubble;
  logic             exmem_flush;
  logic [1:0]       hz_state;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_rs, id_rt, id_rd,
    output id_uses_rs, id_uses_rt,
    output id_regdst, id_regwrite,
    output branch_taken, freeze,
    input  pc_we, ifid_we, ifid_flush,
    input  idex_bubble, exmem_flush,
    input  hz_state, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_rd,
    input  id_uses_rs, id_uses_rt,
    input  id_regdst, id_regwrite,
    input  branch_taken, freeze,
    output pc_we, ifid_we, ifid_flush,
    output idex_bubble, exmem_flush,
    output hz_state, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctl.sv
// Interlock controller for the no-forwarding 5-stage MIPS pipeline.
// HAZARD_STATS_EN builds saturating stall/flush counters.
module hazard_ctl #(
  parameter int WB_WRITE_FIRST = 1,
  parameter int CNT_W          = 16
) (
  input  logic         clk,
  input  logic         reset,
  hazard_ctl_if.slave  bus
);

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    STALL  = 2'b01,
    FLUSH  = 2'b10,
    FROZEN = 2'b11
  } hz_state_t;

  typedef struct packed {
    logic       v;
    logic [4:0] r;
  } sb_t;

  sb_t       sb_ex, sb_mem, sb_wb;
  sb_t       ex_n, mem_n, wb_n;
  sb_t       id_ent;
  logic [4:0] id_dst;
  logic      hz;
  hz_state_t st_q, st_n;

  logic pc_we, ifid_we, ifid_flush;
  logic idex_bubble, exmem_flush;

  function automatic logic hit(
    input sb_t        s,
    input logic [4:0] rs,
    input logic [4:0] rt,
    input logic       urs,
    input logic       urt
  );
    return s.v && (s.r != 5'd0) &&
           ((urs && s.r == rs) ||
            (urt && s.r == rt));
  endfunction

  // Decode ID destination and compare it against in-flight slots.
  always_comb begin
    id_dst   = bus.id_regdst ? bus.id_rd : bus.id_rt;
    id_ent.v = bus.id_regwrite && (id_dst != 5'd0);
    id_ent.r = id_dst;
    hz = hit(sb_ex, bus.id_rs, bus.id_rt,
             bus.id_uses_rs, bus.id_uses_rt) ||
         hit(sb_mem, bus.id_rs, bus.id_rt,
             bus.id_uses_rs, bus.id_uses_rt) ||
         ((WB_WRITE_FIRST == 0) &&
          hit(sb_wb, bus.id_rs, bus.id_rt,
              bus.id_uses_rs, bus.id_uses_rt));
  end

  // Prioritised controls and scoreboard/state next values.
  always_comb begin
    pc_we       = 1'b1;
    ifid_we     = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    exmem_flush = 1'b0;
    ex_n        = id_ent;
    mem_n       = sb_ex;
    wb_n        = sb_mem;
    st_n        = RUN;
    if (reset) begin
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      exmem_flush = 1'b1;
      ex_n        = '0;
      mem_n       = '0;
      wb_n        = '0;
      st_n        = RUN;
    end else if (bus.freeze) begin
      pc_we   = 1'b0;
      ifid_we = 1'b0;
      ex_n    = sb_ex;
      mem_n   = sb_mem;
      wb_n    = sb_wb;
      st_n    = FROZEN;
    end else if (bus.branch_taken) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      exmem_flush = 1'b1;
      ex_n        = '0;
      mem_n       = '0;
      st_n        = FLUSH;
    end else if (hz) begin
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      idex_bubble = 1'b1;
      ex_n        = '0;
      st_n        = STALL;
    end
  end

  // Scoreboard shift and diagnostic state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      sb_ex  <= '0;
      sb_mem <= '0;
      sb_wb  <= '0;
      st_q   <= RUN;
    end else begin
      sb_ex  <= ex_n;
      sb_mem <= mem_n;
      sb_wb  <= wb_n;
      st_q   <= st_n;
    end
  end

  assign bus.pc_we       = pc_we;
  assign bus.ifid_we     = ifid_we;
  assign bus.ifid_flush  = ifid_flush;
  assign bus.idex_bubble = idex_bubble;
  assign bus.exmem_flush = exmem_flush;
  assign bus.hz_state    = st_q;

`ifdef HAZARD_STATS_EN
  logic [CNT_W-1:0] stall_q, flush_q;

  // Saturating counters; st_n is never STALL/FLUSH while frozen.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (st_n == STALL && stall_q != '1)
        stall_q <= stall_q + 1'b1;
      if (st_n == FLUSH && flush_q != '1)
        flush_q <= flush_q + 1'b1;
    end
  end

  assign bus.stall_cnt = stall_q;
  assign bus.flush_cnt = flush_q;
`else
  assign bus.stall_cnt = '0;
  assign bus.flush_cnt = '0;
`endif

endmodule
